// File: rtl/i2s_rx_packer.sv
// i2s_rx_packer: I2S receiver that packs {chan, seq, sample} words behind a valid/ready holding register.
// The drop counter on ovf_count is built only when I2S_RX_PACKER_OVF_CNT_EN is defined.
module i2s_rx_packer #(
    parameter int SAMPLE_BITS = 24,
    parameter int DATA_SIZE   = 28
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 bclk,
    input  logic                 lrclk,
    input  logic                 sdata,
    output logic                 source_valid,
    output logic [DATA_SIZE-1:0] source_data,
    input  logic                 source_ready,
    output logic                 frame_err,
    output logic [7:0]           ovf_count
);
    localparam int CW = $clog2(SAMPLE_BITS + 1);
    typedef enum logic [1:0] {IDLE, DELAY, SHIFT, WAIT} state_t;
    state_t                 r_state, w_next;
    logic [1:0]             r_bclk_s, r_lr_s, r_sd_s;
    logic                   r_bclk_d, r_lr_last, r_armed, r_chan;
    logic [CW-1:0]          r_cnt;
    logic [SAMPLE_BITS-1:0] r_shift;
    logic [2:0]             r_seq;
    logic                   w_rise, w_lr, w_sd, w_chg, w_last, w_done, w_err, w_load, w_acc;
    logic [SAMPLE_BITS-1:0] w_word;
    assign w_rise = r_bclk_s[1] & ~r_bclk_d;
    assign w_lr   = r_lr_s[1];
    assign w_sd   = r_sd_s[1];
    // The first bit clock after reset only records lrclk, so a level already present is not mistaken for an edge.
    assign w_chg  = w_rise & r_armed & (w_lr != r_lr_last);
    assign w_last = r_cnt == CW'(SAMPLE_BITS - 1);
    assign w_done = w_rise & (r_state == SHIFT) & w_last;
    assign w_word = {r_shift[SAMPLE_BITS-2:0], w_sd};
    assign w_acc  = source_valid & source_ready;
    assign w_load = w_done & (~source_valid | source_ready);
    // Two-flop synchronizers plus a delayed bclk copy for rise detection.
    always_ff @(posedge clk) begin
        if (!reset) begin
            r_bclk_s <= '0;
            r_lr_s   <= '0;
            r_sd_s   <= '0;
            r_bclk_d <= 1'b0;
        end else begin
            r_bclk_s <= {r_bclk_s[0], bclk};
            r_lr_s   <= {r_lr_s[0], lrclk};
            r_sd_s   <= {r_sd_s[0], sdata};
            r_bclk_d <= r_bclk_s[1];
        end
    end
    // Slot FSM state register.
    always_ff @(posedge clk) begin
        if (!reset) r_state <= IDLE;
        else        r_state <= w_next;
    end
    // Next state: every slot boundary re-enters DELAY; a boundary inside SHIFT before the last bit is a framing error.
    always_comb begin
        w_next = r_state;
        w_err  = 1'b0;
        if (w_rise) begin
            case (r_state)
                IDLE:    w_next = w_chg ? DELAY : IDLE;
                DELAY:   w_next = SHIFT;
                SHIFT: begin
                    w_next = w_chg ? DELAY : (w_last ? WAIT : SHIFT);
                    w_err  = w_chg & ~w_last;
                end
                default: w_next = w_chg ? DELAY : WAIT;
            endcase
        end
    end
    // Bit capture: the rise that reveals the new lrclk is the I2S delay bit, so the MSB arrives on the rise seen in DELAY.
    always_ff @(posedge clk) begin
        if (!reset) begin
            r_armed   <= 1'b0;
            r_lr_last <= 1'b0;
            r_chan    <= 1'b0;
            r_cnt     <= '0;
            r_shift   <= '0;
            r_seq     <= '0;
        end else if (w_rise) begin
            r_armed   <= 1'b1;
            r_lr_last <= w_lr;
            if (r_state == DELAY) begin
                r_shift <= w_word;
                r_cnt   <= CW'(1);
                r_chan  <= w_lr;
            end else if (r_state == SHIFT) begin
                r_shift <= w_word;
                r_cnt   <= r_cnt + CW'(1);
            end else begin
                r_cnt   <= '0;
            end
            if (w_done && r_chan) r_seq <= r_seq + 3'd1;
        end
    end
    // Holding register: a completed word loads when the slot is empty or being accepted this cycle.
    always_ff @(posedge clk) begin
        if (!reset) begin
            source_valid <= 1'b0;
            source_data  <= '0;
            frame_err    <= 1'b0;
        end else begin
            if (w_load) begin
                source_valid <= 1'b1;
                source_data  <= {r_chan, r_seq, w_word};
            end else if (w_acc) begin
                source_valid <= 1'b0;
            end
            if (w_err) frame_err <= 1'b1;
        end
    end
`ifdef I2S_RX_PACKER_OVF_CNT_EN
    logic w_drop;
    assign w_drop = w_done & source_valid & ~source_ready;
    // Saturating count of words lost because the held word was not taken.
    always_ff @(posedge clk) begin
        if (!reset)                        ovf_count <= '0;
        else if (w_drop && ovf_count != 8'hFF) ovf_count <= ovf_count + 8'd1;
    end
`else
    assign ovf_count = '0;
`endif
endmodule

// File: doc/i2s_rx_packer.md
I2S_RX_PACKER -- requirements
Module: i2s_rx_packer

Interface
REQ-001 Parameter SAMPLE_BITS, 24, audio sample width captured per channel slot.
REQ-002 Parameter DATA_SIZE, 28, output word width; SHALL equal SAMPLE_BITS+4.
REQ-003 clk  input  1  system clock, 50 MHz.
REQ-004 reset  input  1  synchronous, active-low reset (asserted when 0).
REQ-005 bclk  input  1  I2S bit clock from codec, asynchronous, at most clk/8.
REQ-006 lrclk  input  1  I2S word select, asynchronous; 0 = left, 1 = right.
REQ-007 sdata  input  1  I2S serial data, asynchronous, MSB first.
REQ-008 source_valid  output  1  output word available.
REQ-009 source_data  output  DATA_SIZE  {chan[27], seq[26:24], sample[23:0]}.
REQ-010 source_ready  input  1  downstream accepts word when high with source_valid.
REQ-011 frame_err  output  1  sticky: a slot ended before SAMPLE_BITS bits were captured.
REQ-012 ovf_count  output  8  saturating count of dropped words.

Function
REQ-013 bclk, lrclk and sdata SHALL each pass through a 2-flop synchronizer; a bclk rise is detected as sync=1 with previous sync=0.
REQ-014 All receive logic SHALL advance only on a detected bclk rise; lrclk and sdata are sampled at that edge.
REQ-015 FSM states: IDLE, DELAY, SHIFT, WAIT.
REQ-016 IDLE -> DELAY on the first lrclk change seen at a bclk rise; data before that is ignored.
REQ-017 DELAY: skip exactly one bclk (I2S one-bit delay), then go to SHIFT with bit counter 0 and chan latched from the new lrclk.
REQ-018 SHIFT: shift sdata in MSB first; on the SAMPLE_BITS-th bit, complete a word and go to WAIT.
REQ-019 WAIT: ignore bits until lrclk changes, then go to DELAY.
REQ-020 An lrclk change in SHIFT SHALL discard the partial word, set frame_err, and go to DELAY.
REQ-021 seq is a 3-bit counter, stamped into each completed word, incremented mod 8 after each completed right-channel word, whether or not that word was dropped.
REQ-022 Output is a single holding register; a completed word loads it and sets source_valid on the next clk.
REQ-023 The word is accepted when source_valid && source_ready; source_valid then clears unless a new word loads in the same cycle.
REQ-024 A word completing in the same cycle as an accept SHALL load with no drop.
REQ-025 A word completing while source_valid=1 and source_ready=0 SHALL be dropped; the held word stays stable and ovf_count increments, saturating at 255.
REQ-026 source_data SHALL NOT change while source_valid=1 and not accepted.
REQ-027 Latency: source_valid rises 1 clk after the clk that detected the final bclk rise of a slot.

Reset
REQ-028 While reset=0 at a clk edge: FSM=IDLE, bit counter=0, seq=0, source_valid=0, source_data=0, frame_err=0, ovf_count=0, synchronizers=0.
REQ-029 Reset asserted mid-slot or with a word pending SHALL discard all state; after release the block resynchronizes via IDLE.

Configuration
REQ-030 Macro I2S_RX_PACKER_OVF_CNT_EN: when defined, ovf_count is implemented as REQ-025 specifies.
REQ-031 Without I2S_RX_PACKER_OVF_CNT_EN, ovf_count SHALL be constant 0 and no counter logic is built; the drop behaviour itself is unchanged.

Verification
REQ-032 Reset, then 3 stereo frames L=0x123456, R=0xABCDEF, bclk=clk/16, ready=1 -> after the first lrclk edge, words 0x0123456, 0x8ABCDEF, 0x1123456, 0x9ABCDEF.
REQ-033 ready held 0 across 2 completed words -> source_data holds the first word, ovf_count=1 (with macro) or 0 (without), frame_err=0.
REQ-034 lrclk toggled after 10 bits of a slot -> no word emitted for that slot, frame_err=1, next full slot is emitted correctly.
REQ-035 ready pulsed high in the exact clk a new word completes -> old word accepted, new word loaded, source_valid stays 1, ovf_count unchanged.
REQ-036 9 full frames with ready=1 -> seq sequence 0..7 then 0 (wraps), one value per frame on both channels.
REQ-037 reset=0 for 1 clk during SHIFT with a word pending -> source_valid=0 next clk; output resumes only after a new lrclk edge.
